// File: rtl/efpga_tcdm_burst_master.sv
// efpga_tcdm_burst_master: turns one read/write burst command into single-word TCDM transactions.
// Ports:
//   efpga_clk, efpga_rst                 clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/len       burst command handshake (len 0 = no-op)
//   wr_valid/ready/data                  write-data input stream
//   rd_valid/ready/data                  read-data output stream (FWFT FIFO)
//   tcdm_req/gnt/wen/addr/be/wdata       request side towards the TCDM CDC interface
//   tcdm_rdata/valid                     in-order responses, one per granted request
//   busy, done, err                      status: not idle, completion pulse, sticky error
module efpga_tcdm_burst_master #(
    parameter int ADDR_WIDTH      = 20,
    parameter int LEN_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RD_FIFO_DEPTH   = 4
) (
    input  logic                  efpga_clk,
    input  logic                  efpga_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [31:0]           wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [31:0]           rd_data,
    output logic                  tcdm_req,
    input  logic                  tcdm_gnt,
    output logic                  tcdm_wen,
    output logic [ADDR_WIDTH-1:0] tcdm_addr,
    output logic [3:0]            tcdm_be,
    output logic [31:0]           tcdm_wdata,
    input  logic [31:0]           tcdm_rdata,
    input  logic                  tcdm_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int CW = $clog2(RD_FIFO_DEPTH) + 1;
    localparam int PW = $clog2(RD_FIFO_DEPTH);
    localparam int SW = (OW > CW ? OW : CW) + 1;
    localparam logic [OW-1:0] MAX_L   = OW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] DEPTH_L = CW'(RD_FIFO_DEPTH);
    localparam logic [SW-1:0] DEPTH_S = SW'(RD_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic                  dir_q, dir_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d, rem_n;
    logic [OW-1:0]         out_q, out_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         wptr_q, rptr_q;
    logic                  req_q, req_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [31:0]           mem [RD_FIFO_DEPTH];
    logic                  accept, grant, valid_ok, pop, push, push_ok, credit_ok, wr_fire;
    logic                  unused_addr_lsb;

    assign unused_addr_lsb = ^cmd_addr[1:0];

    assign accept    = cmd_valid & cmd_ready;
    assign grant     = req_q & tcdm_gnt;
    // a response with nothing outstanding is spurious and must not underflow the counter
    assign valid_ok  = tcdm_valid & (out_q != '0);
    assign out_d     = out_q + OW'(grant) - OW'(valid_ok);
    assign rem_n     = rem_q - LEN_WIDTH'(grant);
    assign pop       = rd_ready & (cnt_q != '0);
    assign push      = valid_ok & ~dir_q;
    assign push_ok   = push & ((cnt_q != DEPTH_L) | pop);
    assign cnt_d     = cnt_q + CW'(push_ok) - CW'(pop);
    // a new read request reserves a FIFO slot: outstanding + stored + new request must fit
    assign credit_ok = ((SW'(out_d) + SW'(cnt_d)) < DEPTH_S) & (out_d < MAX_L);
    assign wr_fire   = wr_valid & wr_ready;

    always_ff @(posedge efpga_clk or posedge efpga_rst) begin
        if (efpga_rst) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (cmd_len == '0) ? DONE : ISSUE;
            ISSUE:   if (rem_n == '0) state_d = DRAIN;
            DRAIN:   if (out_d == '0) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // a write beat is taken only when the request slot is free after this cycle
    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        wr_ready  = (state_q == ISSUE) & dir_q & (rem_n != '0) & ~(req_q & ~tcdm_gnt) & (out_d < MAX_L);
    end

    // a pending request is held until granted; a grant may be followed back-to-back
    always_comb begin
        dir_d   = accept ? cmd_write : dir_q;
        addr_d  = accept ? {cmd_addr[ADDR_WIDTH-1:2], 2'b00} : (grant ? addr_q + ADDR_WIDTH'(4) : addr_q);
        rem_d   = accept ? cmd_len : rem_n;
        req_d   = (req_q & ~tcdm_gnt) | ((state_q == ISSUE) & (rem_n != '0) & (dir_q ? wr_fire : credit_ok));
        wdata_d = wr_fire ? wr_data : wdata_q;
        err_d   = accept ? 1'b0 : (err_q | (tcdm_valid & (out_q == '0)) | (push & ~push_ok));
    end

    always_ff @(posedge efpga_clk or posedge efpga_rst) begin
        if (efpga_rst) begin
            dir_q   <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            req_q   <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            dir_q   <= dir_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_q + PW'(push_ok);
            rptr_q  <= rptr_q + PW'(pop);
            req_q   <= req_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge efpga_clk) begin
        if (push_ok) mem[wptr_q] <= tcdm_rdata;
    end

    assign tcdm_req   = req_q;
    assign tcdm_wen   = ~dir_q;
    assign tcdm_addr  = addr_q;
    assign tcdm_be    = 4'hF;
    assign tcdm_wdata = wdata_q;
    assign rd_valid   = (cnt_q != '0);
    // storage is not reset, so the head word is masked while the FIFO is empty
    assign rd_data    = rd_valid ? mem[rptr_q] : 32'h0;
    assign err        = err_q;
endmodule
